write_level_monitor: RTL and testbench

Write-clock-domain companion to the write pointer/full logic of the dual-clock async FIFO. It takes the read-domain Gray read pointer and synchronizes it into `wclk`, which produces `wq2_read_ptr` for the full comparison. It then decodes both Gray pointers back to binary and publishes a registered fill level, free count, almost-full flag and sticky overflow error to the write-side producer.

---
 rtl/write_level_monitor.sv | 91 +++++++++
 tb/tb_write_level_monitor.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_level_monitor.sv
// Write-domain fill monitor: synchronizes the Gray read pointer into wclk and
// publishes registered level/free/almost-full and (with WLEVEL_OVERFLOW_DETECT_EN) a sticky overflow flag.
module write_level_monitor #(
  parameter int ADDRESS_SIZE = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [ADDRESS_SIZE:0] rptr,
  input  logic [ADDRESS_SIZE:0] write_ptr,
  input  logic                  winc,
  input  logic                  wfull,
  input  logic [ADDRESS_SIZE:0] afull_thresh,
  input  logic                  clr_ovf,
  output logic [ADDRESS_SIZE:0] wq2_read_ptr,
  output logic [ADDRESS_SIZE:0] wlevel,
  output logic [ADDRESS_SIZE:0] wfree,
  output logic                  walmost_full,
  output logic                  woverflow
);

  localparam int PW = ADDRESS_SIZE + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRESS_SIZE{1'b0}}};

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] diff;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain; only stage 0 ever samples the foreign-domain rptr.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wq2_read_ptr = sync_q[SYNC_STAGES-1];

  always_comb begin
    wbin = gray2bin(write_ptr);
    rbin = gray2bin(wq2_read_ptr);
    // Modular subtract absorbs pointer wrap; no saturation by design.
    diff = wbin - rbin;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel       <= '0;
      wfree        <= DEPTH;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= diff;
      wfree        <= DEPTH - diff;
      walmost_full <= (diff >= afull_thresh);
    end
  end

`ifdef WLEVEL_OVERFLOW_DETECT_EN
  // Set has priority over clear so a simultaneous overflow is never lost.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow <= 1'b0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
    end else if (clr_ovf) begin
      woverflow <= 1'b0;
    end
  end
`else
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = ^{winc, wfull, clr_ovf};
  assign woverflow = 1'b0;
`endif

endmodule

// File: tb/tb_write_level_monitor.sv
// Self-checking bench for write_level_monitor (ADDRESS_SIZE=4, SYNC_STAGES=2),
// scoreboard of expected output vectors plus directed checks per scenario.
module tb_write_level_monitor;

  localparam int AS = 4;
  localparam int SS = 2;
  localparam int PW = AS + 1;
  localparam int EW = 3 * PW + 2;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic [PW-1:0] rptr;
  logic [PW-1:0] write_ptr;
  logic          winc;
  logic          wfull;
  logic [PW-1:0] afull_thresh;
  logic          clr_ovf;
  logic [PW-1:0] wq2_read_ptr;
  logic [PW-1:0] wlevel;
  logic [PW-1:0] wfree;
  logic          walmost_full;
  logic          woverflow;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [PW-1:0] m_s0;
  logic [PW-1:0] m_s1;
  logic          m_ovf;

  write_level_monitor #(.ADDRESS_SIZE(AS), .SYNC_STAGES(SS)) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .rptr(rptr),
    .write_ptr(write_ptr),
    .winc(winc),
    .wfull(wfull),
    .afull_thresh(afull_thresh),
    .clr_ovf(clr_ovf),
    .wq2_read_ptr(wq2_read_ptr),
    .wlevel(wlevel),
    .wfree(wfree),
    .walmost_full(walmost_full),
    .woverflow(woverflow)
  );

  // clock / reset
  always #5 wclk = ~wclk;

  function automatic logic [PW-1:0] to_gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input logic [PW-1:0] g);
    int b;
    b = 0;
    for (int s = 0; s < PW; s++) b = b ^ int'(g >> s);
    return b;
  endfunction

  task automatic reset_model();
    m_s0 = '0;
    m_s1 = '0;
    m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // driver + scoreboard: push the vector expected after the next edge, then pop and compare
  task automatic step();
    int lvl;
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    lvl = (from_gray(write_ptr) - from_gray(m_s1) + 32) % 32;
`ifdef WLEVEL_OVERFLOW_DETECT_EN
    if (winc && wfull) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
`else
    m_ovf = 1'b0;
`endif
    e = {m_s0, PW'(lvl), PW'(16 - lvl), (lvl >= int'(afull_thresh)), m_ovf};
    m_s1 = m_s0;
    m_s0 = rptr;
    exp_q.push_back(e);
    @(posedge wclk);
    @(negedge wclk);
    e = exp_q.pop_front();
    got = {wq2_read_ptr, wlevel, wfree, walmost_full, woverflow};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t got {wq2,lvl,free,af,ovf}=%h/%0d/%0d/%b/%b expected %h/%0d/%0d/%b/%b",
               $time, got[16:12], got[11:7], got[6:2], got[1], got[0],
               e[16:12], e[11:7], e[6:2], e[1], e[0]);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (wq2_read_ptr !== 5'd0 || wlevel !== 5'd0 || wfree !== 5'd16 ||
        walmost_full !== 1'b0 || woverflow !== 1'b0) begin
      errors++;
      $display("FAIL %s got wq2=%0d lvl=%0d free=%0d af=%b ovf=%b expected 0/0/16/0/0",
               name, wq2_read_ptr, wlevel, wfree, walmost_full, woverflow);
    end
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    rptr = '0; write_ptr = '0; winc = 0; wfull = 0; clr_ovf = 0;
    afull_thresh = 5'd12;
    reset_model();
    #12;
    check_reset_values("reset_state");
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_reset_values("reset_hold_10");
  endtask

  task automatic test_fill();
    afull_thresh = 5'd12;
    for (int i = 1; i <= 16; i++) begin
      write_ptr = to_gray(i);
      step();
      checks++;
      if (wlevel !== PW'(i) || walmost_full !== (i >= 12)) begin
        errors++;
        $display("FAIL fill_%0d got lvl=%0d af=%b expected %0d/%b", i, wlevel, walmost_full, i, (i >= 12));
      end
    end
    checks++;
    if (wfree !== 5'd0) begin
      errors++;
      $display("FAIL fill_free got %0d expected 0", wfree);
    end
  endtask

  task automatic test_read_catchup();
    rptr = to_gray(5);
    step();
    step();
    checks++;
    if (wq2_read_ptr !== to_gray(5) || wlevel !== 5'd16) begin
      errors++;
      $display("FAIL sync_latency got wq2=%h lvl=%0d expected %h/16", wq2_read_ptr, wlevel, to_gray(5));
    end
    step();
    checks++;
    if (wlevel !== 5'd11 || wfree !== 5'd5 || walmost_full !== 1'b0) begin
      errors++;
      $display("FAIL read_catchup got lvl=%0d free=%0d af=%b expected 11/5/0", wlevel, wfree, walmost_full);
    end
  endtask

  task automatic test_wrap();
    write_ptr = to_gray(1);
    rptr = to_gray(30);
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (wlevel !== 5'd3 || wfree !== 5'd13) begin
      errors++;
      $display("FAIL wrap got lvl=%0d free=%0d expected 3/13", wlevel, wfree);
    end
  endtask

  task automatic test_thresh_bounds();
    rptr = to_gray(0);
    write_ptr = to_gray(16);
    afull_thresh = 5'd17;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (wlevel !== 5'd16 || walmost_full !== 1'b0) begin
      errors++;
      $display("FAIL thresh_17 got lvl=%0d af=%b expected 16/0", wlevel, walmost_full);
    end
    afull_thresh = 5'd16;
    step();
    checks++;
    if (walmost_full !== 1'b1) begin
      errors++;
      $display("FAIL thresh_16 got af=%b expected 1", walmost_full);
    end
    write_ptr = to_gray(0);
    afull_thresh = 5'd0;
    step();
    checks++;
    if (wlevel !== 5'd0 || walmost_full !== 1'b1) begin
      errors++;
      $display("FAIL thresh_0 got lvl=%0d af=%b expected 0/1", wlevel, walmost_full);
    end
    afull_thresh = 5'd12;
  endtask

  task automatic test_overflow();
    logic exp1;
`ifdef WLEVEL_OVERFLOW_DETECT_EN
    exp1 = 1'b1;
`else
    exp1 = 1'b0;
`endif
    winc = 1; wfull = 0;
    step();
    checks++;
    if (woverflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_not_full got %b expected 0", woverflow);
    end
    wfull = 1;
    step();
    winc = 0; wfull = 0;
    step();
    step();
    checks++;
    if (woverflow !== exp1) begin
      errors++;
      $display("FAIL ovf_sticky got %b expected %b", woverflow, exp1);
    end
    winc = 1; wfull = 1; clr_ovf = 1;
    step();
    checks++;
    if (woverflow !== exp1) begin
      errors++;
      $display("FAIL ovf_set_wins got %b expected %b", woverflow, exp1);
    end
    winc = 0; wfull = 0;
    step();
    clr_ovf = 0;
    checks++;
    if (woverflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b expected 0", woverflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      rptr = to_gray($urandom_range(0, 31));
      write_ptr = to_gray($urandom_range(0, 31));
      afull_thresh = PW'($urandom_range(0, 20));
      winc = 1'($urandom_range(0, 1));
      wfull = 1'($urandom_range(0, 1));
      clr_ovf = 1'($urandom_range(0, 1));
      step();
    end
    winc = 0; wfull = 0; clr_ovf = 0;
    afull_thresh = 5'd12;
  endtask

  task automatic test_reset_mid();
    rptr = to_gray(3);
    write_ptr = to_gray(12);
    winc = 1; wfull = 1;
    for (int i = 0; i < 3; i++) step();
    winc = 0; wfull = 0;
    checks++;
    if (wlevel !== 5'd9) begin
      errors++;
      $display("FAIL mid_setup got lvl=%0d expected 9", wlevel);
    end
    #2;
    wrst_n = 1'b0;
    #1;
    check_reset_values("reset_async");
    reset_model();
    write_ptr = to_gray(0);
    @(negedge wclk);
    wrst_n = 1'b1;
    step();
    checks++;
    if (wlevel !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_1 got lvl=%0d expected 0", wlevel);
    end
    step();
    step();
    checks++;
    if (wlevel !== 5'd29 || wfree !== 5'd19) begin
      errors++;
      $display("FAIL post_reset_3 got lvl=%0d free=%0d expected 29/19", wlevel, wfree);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read_catchup();
    test_wrap();
    test_thresh_bounds();
    test_overflow();
    test_random();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
